main_cntrl_fsm: RTL and testbench
=================================

# main_cntrl_fsm

Multicycle main control unit for the MIPS datapath: a Moore-style state machine, with memory-ready qualification on a few outputs, that sequences each instruction through fetch, decode, execute, memory and write-back. It sits upstream of the ALU control decoder and drives its `alu_op` input. It also generates every datapath enable and mux select, plus per-instruction completion and illegal-opcode strobes for the bench and the performance counters.

## Interface
- No parameters. Opcodes are fixed:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - addi 001000
  - j 000010
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `opcode` input 6: instr[31:26] from the IR; stable from DECODE onward.
- `mem_ready` input 1: memory completes the current access this cycle.
- `pc_write`, `pc_write_cond` output 1 each: PC enable, and branch-conditional PC enable.
- `iord` output 1: memory address select; 0=PC, 1=ALUOut.
- `mem_read`, `mem_write`, `ir_write` output 1 each: memory strobes and IR load.
- `mem_to_reg`, `reg_dst`, `reg_write` output 1 each: write-back controls.
- `alu_src_a` output 1: 0=PC, 1=A.
- `alu_src_b` output 2: 00=B, 01=4, 10=sign-extended imm, 11=imm<<2.
- `alu_op` output 2: 00=add, 01=sub, 10=use funct. Goes to the ALU control decoder.
- `pc_source` output 2: 00=ALU result, 01=ALUOut, 10=jump target.
- `instr_done` output 1: one-cycle strobe in the final cycle of each instruction.
- `illegal_op` output 1: strobe in DECODE when the opcode is unrecognised.
- `state_id` output 4: current state encoding, for debug.

## Operation
- States and encodings:
  - INIT 0, FETCH 1, DECODE 2, MEM_ADDR 3
  - MEM_READ 4, MEM_WB 5, MEM_WRITE 6, R_EXEC 7
  - R_WB 8, BRANCH 9, ADDI_EXEC 10, ADDI_WB 11, JUMP 12
- Encodings 13–15 are unreachable. If entered, all outputs are 0 and next state is FETCH.
- All outputs default to 0 in every state. Only the values listed below are asserted.
- INIT: all outputs 0. Next state is FETCH.
- FETCH:
  - Asserts mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write equal mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Asserts alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - Next state by opcode: lw/sw→MEM_ADDR, R→R_EXEC, beq→BRANCH, addi→ADDI_EXEC, j→JUMP.
  - Any other opcode → FETCH, with illegal_op=1 in this cycle.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, iord=1. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next state FETCH.
- MEM_WRITE:
  - mem_write=1, iord=1, held until mem_ready.
  - instr_done equals mem_ready.
  - Goes to FETCH on mem_ready.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Next state FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next state FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Next state FETCH.
- The opcode is sampled combinationally in DECODE and in MEM_ADDR only. Opcode changes in any other state are ignored.
- mem_ready is ignored in every state except FETCH, MEM_READ and MEM_WRITE.

## Timing
- Only the state register is sequential; outputs decode from state, plus mem_ready where stated above.
- While rst_n=0, the state is INIT immediately (asynchronous), regardless of clk, and all outputs are 0.
- After rst_n deassertion, the first rising edge moves INIT→FETCH.
- Reset asserted mid-instruction aborts it at once: no strobe completes after rst_n falls.
- Instruction latency in cycles, with mem_ready held at 1:
  - lw 5
  - sw, R-type, addi 4
  - beq, j 3
- Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- instr_done pulses exactly once per legal instruction. illegal_op pulses exactly once per illegal fetch.
- The two strobes are never asserted together.

## Test plan
- Reset: hold rst_n=0 across 3 edges, then release.
  - Required: all outputs 0 and state_id=0 during reset.
  - Required: state_id=1 after the first edge, with mem_read=1, alu_src_b=01, pc_write=1 when mem_ready=1.
- lw with mem_ready=1.
  - Required: state_id sequence 1,2,3,4,5,1.
  - Required: alu_op=00 throughout, reg_write=1 and mem_to_reg=1 only in state 5.
  - Required: instr_done high in exactly 1 of the 5 cycles.
- R-type, then beq.
  - Required: alu_op=10 in R_EXEC, then reg_dst=1 and reg_write=1 in R_WB.
  - Required: beq has alu_op=01, pc_write_cond=1, pc_source=01.
  - Required: total 4+3 cycles.
- sw with mem_ready=0 for 3 cycles in MEM_WRITE.
  - Required: mem_write=1 held for 4 cycles, state_id=6 throughout.
  - Required: instr_done only in the mem_ready=1 cycle.
  - Required: FETCH stall behaves the same way, with ir_write=0 and pc_write=0 while mem_ready=0.
- Opcode 111111.
  - Required: illegal_op=1 for one DECODE cycle, then state_id=1, no instr_done.
- j, then addi.
  - Required: j has pc_write=1 and pc_source=10 in state 12.
  - Required: addi sequence 1,2,10,11 with alu_src_b=10.
  - Required: rst_n dropped in state 10 gives outputs 0 within the same cycle, with no reg_write.

Source files
------------

// File: rtl/main_cntrl_fsm.sv
// main_cntrl_fsm: multicycle MIPS main control FSM (fetch/decode/execute/mem/write-back)
//   in : clk, rst_n (async active-low), opcode[5:0], mem_ready
//   out: pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
//        reg_dst, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0],
//        instr_done, illegal_op, state_id[3:0]
module main_cntrl_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state_id
);
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  typedef enum logic [3:0] {
    INIT = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEM_ADDR = 4'd3, MEM_READ = 4'd4,
    MEM_WB = 4'd5, MEM_WRITE = 4'd6, R_EXEC = 4'd7, R_WB = 4'd8, BRANCH = 4'd9,
    ADDI_EXEC = 4'd10, ADDI_WB = 4'd11, JUMP = 4'd12
  } state_t;
  state_t state, next;
  logic is_mem;
  assign is_mem = (opcode == OP_LW) || (opcode == OP_SW);
  assign state_id = state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= INIT;
    else state <= next;
  always_comb begin
    next = FETCH;
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    iord = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op = 2'b00;
    pc_source = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state)
      INIT: next = FETCH;
      FETCH: begin
        mem_read = 1'b1;
        alu_src_b = 2'b01;
        ir_write = mem_ready;
        pc_write = mem_ready;
        next = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        next = is_mem ? MEM_ADDR :
               opcode == OP_R ? R_EXEC :
               opcode == OP_BEQ ? BRANCH :
               opcode == OP_ADDI ? ADDI_EXEC :
               opcode == OP_J ? JUMP : FETCH;
        illegal_op = !(is_mem || opcode == OP_R || opcode == OP_BEQ ||
                       opcode == OP_ADDI || opcode == OP_J);
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        next = opcode == OP_SW ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        iord = 1'b1;
        next = mem_ready ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        reg_write = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        iord = 1'b1;
        instr_done = mem_ready;
        next = mem_ready ? FETCH : MEM_WRITE;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op = 2'b10;
        next = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op = 2'b01;
        pc_write_cond = 1'b1;
        pc_source = 2'b01;
        instr_done = 1'b1;
      end
      ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        next = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write = 1'b1;
        instr_done = 1'b1;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_source = 2'b10;
        instr_done = 1'b1;
      end
      default: next = FETCH;
    endcase
  end
endmodule

// File: tb/tb_main_cntrl_fsm.sv
// tb_main_cntrl_fsm: scoreboard bench for main_cntrl_fsm driven by directed per-cycle vectors
module tb_main_cntrl_fsm;
  logic clk = 1'b1;
  logic rst_n;
  logic [5:0] opcode;
  logic mem_ready;
  logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_id;
  logic [21:0] got;
  int checks = 0;
  int fails = 0;
  typedef struct {
    logic [21:0] v;
    string n;
  } exp_t;
  exp_t q[$];
  localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2b, BEQ = 6'h04,
                         ADDI = 6'h08, J = 6'h02, ILL = 6'h3f;
  localparam logic [21:0] E_INIT = {4'd0, 18'b0};
  localparam logic [21:0] E_F1 = {4'd1, 10'b1001010000, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam logic [21:0] E_F0 = {4'd1, 10'b0001000000, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam logic [21:0] E_DEC = {4'd2, 10'b0000000000, 2'b11, 2'b00, 2'b00, 2'b00};
  localparam logic [21:0] E_DILL = {4'd2, 10'b0000000000, 2'b11, 2'b00, 2'b00, 2'b01};
  localparam logic [21:0] E_MADR = {4'd3, 10'b0000000001, 2'b10, 2'b00, 2'b00, 2'b00};
  localparam logic [21:0] E_MRD = {4'd4, 10'b0011000000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [21:0] E_MWB = {4'd5, 10'b0000001010, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [21:0] E_MW0 = {4'd6, 10'b0010100000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [21:0] E_MW1 = {4'd6, 10'b0010100000, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [21:0] E_REX = {4'd7, 10'b0000000001, 2'b00, 2'b10, 2'b00, 2'b00};
  localparam logic [21:0] E_RWB = {4'd8, 10'b0000000110, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [21:0] E_BR = {4'd9, 10'b0100000001, 2'b00, 2'b01, 2'b01, 2'b10};
  localparam logic [21:0] E_AEX = {4'd10, 10'b0000000001, 2'b10, 2'b00, 2'b00, 2'b00};
  localparam logic [21:0] E_AWB = {4'd11, 10'b0000000010, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [21:0] E_JMP = {4'd12, 10'b1000000000, 2'b00, 2'b00, 2'b10, 2'b10};
  main_cntrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
    .state_id(state_id)
  );
  assign got = {state_id, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                instr_done, illegal_op};
  always #5 clk = ~clk;
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (got !== e.v) begin
        fails++;
        $display("FAIL %s: got %h expected %h", e.n, got, e.v);
      end
    end
  task automatic cyc(input logic [5:0] op, input logic mr, input logic [21:0] v, input string n);
    opcode = op;
    mem_ready = mr;
    q.push_back('{v, n});
    @(posedge clk);
    #1;
  endtask
  task automatic dchk(input logic [21:0] v, input string n);
    checks++;
    if (got !== v) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, got, v);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    opcode = R;
    mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) cyc(LW, 1'b1, E_INIT, "reset_hold");
    rst_n = 1'b1;
    cyc(LW, 1'b1, E_INIT, "init_after_release");
    cyc(LW, 1'b1, E_F1, "lw_fetch");
    cyc(LW, 1'b1, E_DEC, "lw_decode");
    cyc(LW, 1'b1, E_MADR, "lw_mem_addr");
    cyc(LW, 1'b1, E_MRD, "lw_mem_read");
    cyc(LW, 1'b1, E_MWB, "lw_mem_wb");
    cyc(R, 1'b1, E_F1, "r_fetch");
    cyc(R, 1'b1, E_DEC, "r_decode");
    cyc(ILL, 1'b0, E_REX, "r_exec_ignores_opcode");
    cyc(ILL, 1'b1, E_RWB, "r_wb");
    cyc(BEQ, 1'b1, E_F1, "beq_fetch");
    cyc(BEQ, 1'b0, E_DEC, "beq_decode");
    cyc(BEQ, 1'b1, E_BR, "beq_branch");
    cyc(SW, 1'b0, E_F0, "sw_fetch_stall1");
    cyc(SW, 1'b0, E_F0, "sw_fetch_stall2");
    cyc(SW, 1'b1, E_F1, "sw_fetch");
    cyc(SW, 1'b0, E_DEC, "sw_decode");
    cyc(SW, 1'b1, E_MADR, "sw_mem_addr");
    cyc(SW, 1'b0, E_MW0, "sw_write_stall1");
    cyc(SW, 1'b0, E_MW0, "sw_write_stall2");
    cyc(SW, 1'b0, E_MW0, "sw_write_stall3");
    cyc(SW, 1'b1, E_MW1, "sw_write_done");
    cyc(LW, 1'b1, E_F1, "lw2_fetch");
    cyc(LW, 1'b1, E_DEC, "lw2_decode");
    cyc(LW, 1'b1, E_MADR, "lw2_mem_addr");
    cyc(LW, 1'b0, E_MRD, "lw2_read_stall");
    cyc(LW, 1'b1, E_MRD, "lw2_mem_read");
    cyc(LW, 1'b1, E_MWB, "lw2_mem_wb");
    cyc(ILL, 1'b1, E_F1, "ill_fetch");
    cyc(ILL, 1'b1, E_DILL, "ill_decode");
    cyc(J, 1'b1, E_F1, "j_fetch_after_ill");
    cyc(J, 1'b1, E_DEC, "j_decode");
    cyc(J, 1'b1, E_JMP, "j_jump");
    cyc(ADDI, 1'b1, E_F1, "addi_fetch");
    cyc(ADDI, 1'b1, E_DEC, "addi_decode");
    opcode = ADDI;
    mem_ready = 1'b1;
    q.push_back('{E_AEX, "addi_exec"});
    #6;
    rst_n = 1'b0;
    #1;
    dchk(E_INIT, "reset_mid_addi_exec");
    @(posedge clk);
    #1;
    cyc(ADDI, 1'b1, E_INIT, "reset_held_after_abort");
    rst_n = 1'b1;
    cyc(ADDI, 1'b1, E_INIT, "init_after_abort");
    cyc(ADDI, 1'b1, E_F1, "fetch_after_abort");
    for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
